// File: rtl/clarvi_reg_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clarvi_reg_write_sequencer_pkg
// Description : Shared register-file types, widths and helpers for the
//               part-write sequencer and the part priority finder.
// Revision    : 1.0 - initial release
// ============================================================================
package clarvi_reg_write_sequencer_pkg;

    localparam int XLEN       = 64;
    localparam int PART_WIDTH = 16;
    localparam int NUM_PARTS  = XLEN / PART_WIDTH;
    localparam int PART_IDX_W = $clog2(NUM_PARTS);

    typedef logic [4:0]            reg_index_t;
    typedef logic [PART_IDX_W-1:0] reg_part_t;
    typedef logic [NUM_PARTS-1:0]  part_mask_t;

    // x0 is hard-wired to zero in the register file and must never be written
    localparam reg_index_t C_ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } seq_state_t;

    // Extract one register-file beat from a full register value
    function automatic logic [PART_WIDTH-1:0] part_slice(input logic [XLEN-1:0] value,
                                                          input reg_part_t       part);
        return value[int'(part)*PART_WIDTH +: PART_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/clarvi_reg_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : clarvi_reg_write_sequencer_if
// Description : Writeback request handshake, register-file part-write port
//               and pending-destination export for the write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface clarvi_reg_write_sequencer_if
    import clarvi_reg_write_sequencer_pkg::*;
();

    // Writeback request side
    logic                   wb_valid;
    logic                   wb_ready;
    reg_index_t             wb_register;
    logic [XLEN-1:0]        wb_value;
    part_mask_t             wb_parts;

    // Register-file write port
    logic                   write_grant;
    logic                   write_enable;
    reg_index_t             write_register;
    reg_part_t              write_part;
    logic [PART_WIDTH-1:0]  data_in;

    // Hazard-detection export
    logic                   pending_valid;
    reg_index_t             pending_register;
    part_mask_t             pending_parts;

    // Sequencer (initiator) view
    modport master (
        input  wb_valid, wb_register, wb_value, wb_parts, write_grant,
        output wb_ready, write_enable, write_register, write_part, data_in,
               pending_valid, pending_register, pending_parts
    );

    // Environment view: writeback stage plus register file
    modport slave (
        output wb_valid, wb_register, wb_value, wb_parts, write_grant,
        input  wb_ready, write_enable, write_register, write_part, data_in,
               pending_valid, pending_register, pending_parts
    );

endinterface
`default_nettype wire

// File: rtl/clarvi_reg_write_sequencer_part_priority.sv
`default_nettype none
// ============================================================================
// Module      : clarvi_part_priority
// Description : Lowest-set-bit finder over a register part mask. Reports the
//               index of the lowest set part, whether any part is set, and
//               whether that part is the only one remaining.
// Revision    : 1.0 - initial release
// ============================================================================
module clarvi_part_priority
    import clarvi_reg_write_sequencer_pkg::*;
(
    input  part_mask_t i_mask,
    output reg_part_t  o_index,
    output logic       o_found,
    output logic       o_is_last
);

    // Mask with its lowest set bit removed; empty means the current part is last
    part_mask_t w_rest;

    assign w_rest = i_mask & (i_mask - part_mask_t'(1));

    // Scan from the top down so the lowest set bit is the final assignment
    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = reg_part_t'(i);
                o_found = 1'b1;
            end
        end
    end

    assign o_is_last = o_found && (w_rest == '0);

endmodule
`default_nettype wire

// File: rtl/clarvi_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clarvi_reg_write_sequencer
// Description : Accepts a full 64-bit writeback and issues it to the register
//               file as 16-bit part writes in ascending part order, one per
//               granted cycle, with back-to-back request acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module clarvi_reg_write_sequencer
    import clarvi_reg_write_sequencer_pkg::*;
(
    input  logic                               clock,
    input  logic                               reset_n,
    clarvi_reg_write_sequencer_if.master       bus
);

    seq_state_t             r_state;
    reg_index_t             r_register;
    logic [XLEN-1:0]        r_value;
    part_mask_t             r_mask;

    reg_part_t              w_idx;
    logic                   w_found;
    logic                   w_is_last;
    logic                   w_active;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_discard;

    clarvi_part_priority u_priority (
        .i_mask    (r_mask),
        .o_index   (w_idx),
        .o_found   (w_found),
        .o_is_last (w_is_last)
    );

    // Outputs are forced quiet while reset is asserted, even before the reset edge
    assign w_active  = reset_n && (r_state == S_WRITE);
    assign w_ready   = reset_n && ((r_state == S_IDLE) ||
                                   (w_active && bus.write_grant && w_found && w_is_last));
    assign w_accept  = bus.wb_valid && w_ready;
    assign w_discard = (bus.wb_register == C_ZERO_REG) || (bus.wb_parts == '0);

    // Request acceptance, beat retirement and back-to-back reload
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_register <= '0;
            r_value    <= '0;
            r_mask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_discard) begin
                        r_state    <= S_WRITE;
                        r_register <= bus.wb_register;
                        r_value    <= bus.wb_value;
                        r_mask     <= bus.wb_parts;
                    end
                end
                S_WRITE: begin
                    if (bus.write_grant) begin
                        r_mask[w_idx] <= 1'b0;
                        if (w_is_last) begin
                            if (w_accept && !w_discard) begin
                                // Later assignment overrides the bit clear above
                                r_register <= bus.wb_register;
                                r_value    <= bus.wb_value;
                                r_mask     <= bus.wb_parts;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wb_ready         = w_ready;
    assign bus.write_enable     = w_active && bus.write_grant;
    assign bus.write_register   = w_active ? r_register : C_ZERO_REG;
    assign bus.write_part       = w_active ? w_idx : '0;
    assign bus.data_in          = w_active ? part_slice(r_value, w_idx) : '0;
    assign bus.pending_valid    = w_active;
    assign bus.pending_register = w_active ? r_register : C_ZERO_REG;
    assign bus.pending_parts    = w_active ? r_mask : '0;

endmodule
`default_nettype wire

// File: doc/clarvi_reg_write_sequencer.md
Name: clarvi_reg_write_sequencer

Overview:
Initiator side of the register file's 16-bit part-write port. Accepts one full 64-bit writeback (register index, value, part mask) over a valid/ready handshake. Issues one 16-bit part write per granted cycle, in ascending part order, on the register file's write_part/write_register/data_in/write_enable interface. Sits between the execute/writeback stage and the register file, and exports the pending destination for hazard detection.

Parameters:
XLEN, 64, full register width in bits
PART_WIDTH, 16, width of one register-file write beat
NUM_PARTS, XLEN/PART_WIDTH (4), derived; beats per full register; part index width is clog2(NUM_PARTS) = 2

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  synchronous, active-low reset
wb_valid  input  1  writeback request valid
wb_ready  output  1  sequencer can accept a request this cycle
wb_register  input  5  destination register index
wb_value  input  XLEN  full value to write
wb_parts  input  NUM_PARTS  mask of parts to write; bit i = bits [16i+15:16i]
write_grant  input  1  register-file write port available this cycle
write_enable  output  1  register-file write strobe
write_register  output  5  register index being written
write_part  output  2  part index being written
data_in  output  PART_WIDTH  part data being written
pending_valid  output  1  a writeback is in progress
pending_register  output  5  register of in-progress writeback
pending_parts  output  NUM_PARTS  parts not yet written, including the current beat

Behaviour:
- Reset (reset_n low at clock edge) forces state IDLE. Held register, value and remaining mask clear to 0.
- Outputs while in reset or IDLE: write_enable=0, write_register=0, write_part=0, data_in=0, pending_valid=0, pending_register=0, pending_parts=0.
- wb_ready = 1 in IDLE when reset_n is high. wb_ready = 0 during reset.
- States are IDLE and WRITE. A request is accepted on a clock edge where wb_valid && wb_ready.
- Accept with wb_register==0 or wb_parts==0: request is consumed and discarded, state stays IDLE, and no write is issued. Register zero is never written.
- Other accepts: latch register, value and mask, then go to WRITE. The first write_enable can occur in the cycle after acceptance (latency 1).
- In WRITE:
  - current part = lowest set bit of the remaining mask; unset parts are skipped with no idle cycle.
  - write_register = held register; write_part = current part; data_in = held value slice for that part.
  - write_enable = write_grant (combinational); all other write outputs hold steady while grant is low.
- On a clock edge with write_grant high, the current part bit clears in the remaining mask.
- Last beat = granted beat where no higher remaining bit is set.
- wb_ready is high during the last beat (combinational on write_grant), giving back-to-back operation. If wb_valid is high on that edge, the new request loads directly into WRITE with no IDLE bubble. Otherwise the state returns to IDLE.
- A discarded request (reg 0 or empty mask) arriving on the last beat returns the sequencer to IDLE.
- Total granted write cycles per request = popcount(wb_parts). Stalls from write_grant=0 add cycles but never reorder or drop beats.
- pending_* outputs are valid throughout WRITE, including stalled cycles.
- pending_parts = remaining mask, with the current part still set until its granted edge.
- Reset mid-operation: the writeback is abandoned. No further write_enable occurs, and parts already written are not undone.
- Input fields are sampled only on the accept edge; later changes to them have no effect.

Decomposition:
- Shared package (clarvi types) holds:
  - reg_index_t (5 bits), reg_part_t (2 bits), part_mask_t (NUM_PARTS bits);
  - constant XLEN/PART_WIDTH;
  - the existing zero register index constant, used for the x0 check.
- One natural sub-module, clarvi_part_priority: combinational lowest-set-bit finder. From a part mask it gives the current index, a found flag and an is-last flag. It is reused by the read-side assembler.

Test Plan:
1. wb_register=5, value=0x1111_2222_3333_4444, parts=4'b1111, grant always 1 -> four writes in consecutive cycles: part0=0x4444, part1=0x3333, part2=0x2222, part3=0x1111, then IDLE.
2. parts=4'b1010, register 7, grant=1 -> exactly two writes: part1, then part3 on the next cycle. Parts 0 and 2 are never strobed.
3. wb_register=0, parts=4'b1111 -> accepted in one cycle, no write_enable ever, wb_ready stays 1.
4. grant pattern 1,0,0,1,1 on a full-mask request -> outputs hold part1 during the stall cycles, and exactly four strobes occur in order.
5. Second request valid during the last beat of the first -> its first write appears in the next cycle with no gap. pending_register switches at that edge.
6. reset_n low after two beats of a 4-part write -> no further write_enable. All outputs read 0 after the reset edge, and wb_ready=1 once reset_n is released.
